core_pipe_ctrl: RTL

CORE_PIPE_CTRL -- requirements
Module: core_pipe_ctrl

---
 rtl/i2d_core_defines.sv | 22 ++
 rtl/core_hazard_det.sv | 29 ++
 rtl/core_pipe_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/i2d_core_defines.sv
// ---------------------------------------------------------------------------
// i2d_core_defines
// Shared definitions for the core pipeline control slice.
//   ctrl_state_t  : pipeline-control FSM state (also exported for debug)
//   FLUSH_CYCLES  : total cycles flush is asserted for one taken branch
//   PC_W / REG_ADDR_W / CNT_W : datapath widths
// ---------------------------------------------------------------------------
package i2d_core_defines;

  localparam int PC_W         = 32;
  localparam int REG_ADDR_W   = 4;
  localparam int CNT_W        = 32;
  localparam int FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2,
    MEMWAIT = 2'd3
  } ctrl_state_t;

endpackage : i2d_core_defines

// File: rtl/core_hazard_det.sv
// ---------------------------------------------------------------------------
// core_hazard_det
// Purely combinational load-use hazard detector. Flags when the instruction
// in EX is a load whose destination is read by the instruction in ID.
//   ex_load, ex_wb_addr      : EX instruction is a load / its destination
//   rega_*, regb_*           : ID source register addresses and use flags
//   load_use                 : hazard present this cycle
// ---------------------------------------------------------------------------
module core_hazard_det
  import i2d_core_defines::*;
(
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_wb_addr,
  input  logic [REG_ADDR_W-1:0] rega_addr,
  input  logic [REG_ADDR_W-1:0] regb_addr,
  input  logic                  rega_used,
  input  logic                  regb_used,
  output logic                  load_use
);

  logic hit_a;
  logic hit_b;

  // An address match only matters if ID actually reads that operand.
  assign hit_a    = rega_used && (rega_addr == ex_wb_addr);
  assign hit_b    = regb_used && (regb_addr == ex_wb_addr);
  assign load_use = ex_load && (hit_a || hit_b);

endmodule : core_hazard_det

// File: rtl/core_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// core_pipe_ctrl
// Pipeline control FSM: memory-wait freeze, taken-branch redirect + flush,
// and load-use stall, resolved by fixed priority
//   mem_busy > ex_branch_taken > load-use hazard.
// Ports:
//   clk, rst (async, active high)
//   mem_busy, ex_load, ex_wb_addr, rega/regb_addr, rega/regb_used,
//   ex_branch_taken, ex_branch_target                      : inputs
//   pc_load, pc_target, if_hold, id_halt, ex_hold, flush,
//   ex_bubble, state                                       : outputs
// Optional feature (macro I2D_PERF_CNT_EN): adds 32-bit wrapping counters
//   stall_cnt (cycles with id_halt) and flush_cnt (pc_load pulses).
// ---------------------------------------------------------------------------
module core_pipe_ctrl
  import i2d_core_defines::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_busy,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_wb_addr,
  input  logic [REG_ADDR_W-1:0] rega_addr,
  input  logic [REG_ADDR_W-1:0] regb_addr,
  input  logic                  rega_used,
  input  logic                  regb_used,
  input  logic                  ex_branch_taken,
  input  logic [PC_W-1:0]       ex_branch_target,
  output logic                  pc_load,
  output logic [PC_W-1:0]       pc_target,
  output logic                  if_hold,
  output logic                  id_halt,
  output logic                  ex_hold,
  output logic                  flush,
  output logic                  ex_bubble,
  output ctrl_state_t           state
`ifdef I2D_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  ctrl_state_t     state_q, state_d;
  ctrl_state_t     resume_q, resume_d;  // state to resume after MEMWAIT
  ctrl_state_t     eff_state;
  logic [1:0]      flush_left_q, flush_left_d;
  logic [PC_W-1:0] pc_target_q, pc_target_d;
  logic            load_use;

  core_hazard_det u_hazard_det (
    .ex_load    (ex_load),
    .ex_wb_addr (ex_wb_addr),
    .rega_addr  (rega_addr),
    .regb_addr  (regb_addr),
    .rega_used  (rega_used),
    .regb_used  (regb_used),
    .load_use   (load_use)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    resume_d     = resume_q;
    flush_left_d = flush_left_q;
    pc_target_d  = pc_target_q;
    pc_load      = 1'b0;
    if_hold      = 1'b0;
    id_halt      = 1'b0;
    ex_hold      = 1'b0;
    flush        = 1'b0;
    ex_bubble    = 1'b0;

    // Once memory completes, MEMWAIT behaves exactly like the state it froze.
    eff_state = (state_q == MEMWAIT) ? resume_q : state_q;

    if (rst) begin
      // Outputs are forced low combinationally while reset is held, so
      // nothing (not even a branch) leaks out before the flops settle.
      state_d = RUN;
    end else if (mem_busy) begin
      if_hold = 1'b1;
      id_halt = 1'b1;
      ex_hold = 1'b1;
      state_d = MEMWAIT;
      if (state_q != MEMWAIT) resume_d = state_q;
    end else if (ex_branch_taken) begin
      // Redirect in the resolving cycle; IF/ID wrong-path ops are flushed
      // now and for the remaining FLUSH_CYCLES-1 cycles in FLUSH.
      pc_load      = 1'b1;
      flush        = 1'b1;
      pc_target_d  = ex_branch_target;
      flush_left_d = 2'(FLUSH_CYCLES - 1);
      state_d      = FLUSH;
    end else begin
      case (eff_state)
        RUN: begin
          if (load_use) begin
            if_hold   = 1'b1;
            id_halt   = 1'b1;
            ex_bubble = 1'b1;
            state_d   = LDSTALL;
          end else begin
            state_d = RUN;
          end
        end
        FLUSH: begin
          flush = 1'b1;
          if (flush_left_q > 2'd1) begin
            flush_left_d = flush_left_q - 2'd1;
            state_d      = FLUSH;
          end else begin
            flush_left_d = 2'd0;
            state_d      = RUN;
          end
        end
        // LDSTALL: the load has moved on, so any hazard flag is stale.
        default: state_d = RUN;
      endcase
    end
  end

  assign pc_target = pc_target_d;
  assign state     = state_q;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      resume_q     <= RUN;
      flush_left_q <= 2'd0;
      pc_target_q  <= '0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      flush_left_q <= flush_left_d;
      pc_target_q  <= pc_target_d;
    end
  end

`ifdef I2D_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, id_halt};
    flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, pc_load};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule : core_pipe_ctrl
